// File: rtl/btn_reader_pkg.sv
// Shared types and helpers for the push-button reader: debounce FSM states
// and the sizing rule for the per-line debounce counter.
package btn_reader_pkg;

  typedef enum logic [1:0] {
    ST_LOW   = 2'd0,
    ST_ARM_H = 2'd1,
    ST_HIGH  = 2'd2,
    ST_ARM_L = 2'd3
  } btn_state_e;

  // Counter must hold 0..DEBOUNCE-1; one extra code keeps DEBOUNCE=1 at one bit.
  function automatic int unsigned dbnc_cnt_width(input int unsigned debounce);
    return $clog2(debounce + 32'd1);
  endfunction

endpackage

// File: rtl/btn_debounce_cell.sv
// One button line: 2-flop synchronizer, debounce FSM with hold counter, and
// registered level / press / release outputs. press_nxt_o feeds the press counter.
module btn_debounce_cell
  import btn_reader_pkg::*;
#(
  parameter int unsigned DEBOUNCE = 1023
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic btn_i,
  output logic state_o,
  output logic press_o,
  output logic release_o,
  output logic press_nxt_o
);

  localparam int unsigned CW = dbnc_cnt_width(DEBOUNCE);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 32'd1);

  logic [1:0]    sync_q;
  logic          sync_s;
  btn_state_e    fsm_q, fsm_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          state_q, state_d;
  logic          press_q, press_d;
  logic          release_q, release_d;

  assign sync_s = sync_q[1];

  // Bring the asynchronous pin into the clock domain.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], btn_i};
    end
  end

  // Debounce next-state: a level is accepted only after DEBOUNCE+1 agreeing samples.
  always_comb begin
    fsm_d     = fsm_q;
    cnt_d     = cnt_q;
    state_d   = state_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (fsm_q)
      ST_LOW: begin
        if (sync_s) begin
          fsm_d = ST_ARM_H;
          cnt_d = '0;
        end else begin
          fsm_d = ST_LOW;
        end
      end
      ST_ARM_H: begin
        if (!sync_s) begin
          fsm_d = ST_LOW;
        end else if (cnt_q == CNT_LAST) begin
          fsm_d   = ST_HIGH;
          state_d = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_HIGH: begin
        if (!sync_s) begin
          fsm_d = ST_ARM_L;
          cnt_d = '0;
        end else begin
          fsm_d = ST_HIGH;
        end
      end
      ST_ARM_L: begin
        if (sync_s) begin
          fsm_d = ST_HIGH;
        end else if (cnt_q == CNT_LAST) begin
          fsm_d     = ST_LOW;
          state_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        fsm_d   = ST_LOW;
        cnt_d   = '0;
        state_d = 1'b0;
      end
    endcase
  end

  // FSM, counter and output registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fsm_q     <= ST_LOW;
      cnt_q     <= '0;
      state_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      fsm_q     <= fsm_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign state_o     = state_q;
  assign press_o     = press_q;
  assign release_o   = release_q;
  assign press_nxt_o = press_d;

endmodule

// File: rtl/btn_reader.sv
// Top-level button reader: WIDTH debounce cells plus a wrapping count of
// accepted presses, updated on the same edge the PRESS pulses assert.
module btn_reader
  import btn_reader_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEBOUNCE  = 1023,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [WIDTH-1:0]     BTN,
  output logic [WIDTH-1:0]     STATE,
  output logic [WIDTH-1:0]     PRESS,
  output logic [WIDTH-1:0]     RELEASE,
  output logic [CNT_WIDTH-1:0] PRESS_COUNT
);

  localparam int unsigned PW = $clog2(WIDTH + 32'd1);

  logic [WIDTH-1:0]     press_nxt_s;
  logic [PW-1:0]        pop_s;
  logic [CNT_WIDTH-1:0] count_q, count_d;

  for (genvar g = 0; g < int'(WIDTH); g++) begin : g_cell
    btn_debounce_cell #(
      .DEBOUNCE(DEBOUNCE)
    ) u_cell (
      .clk_i      (CLK),
      .rst_n_i    (RST),
      .btn_i      (BTN[g]),
      .state_o    (STATE[g]),
      .press_o    (PRESS[g]),
      .release_o  (RELEASE[g]),
      .press_nxt_o(press_nxt_s[g])
    );
  end

  // Popcount of presses accepted this edge; truncation before the add is harmless mod 2^CNT_WIDTH.
  always_comb begin
    pop_s = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      pop_s = pop_s + PW'(press_nxt_s[i]);
    end
    count_d = count_q + CNT_WIDTH'(pop_s);
  end

  // Press accumulator register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign PRESS_COUNT = count_q;

endmodule

// File: tb/tb_btn_reader.sv
// Bench for btn_reader: directed scenarios plus random button traffic, all
// checked each cycle against a run-length model of the debounce rule.
module tb_btn_reader;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int CW = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic [W-1:0]  BTN = '0;
  logic [W-1:0]  STATE, PRESS, RELEASE;
  logic [CW-1:0] PRESS_COUNT;

  btn_reader #(.WIDTH(W), .DEBOUNCE(D), .CNT_WIDTH(CW)) dut (
    .CLK(CLK), .RST(RST), .BTN(BTN),
    .STATE(STATE), .PRESS(PRESS), .RELEASE(RELEASE), .PRESS_COUNT(PRESS_COUNT)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  // Model: pin pipeline, accepted level, and how many consecutive samples disagree with it.
  logic [W-1:0]  p1, p2, exp_state, exp_press, exp_release;
  logic [CW-1:0] exp_count;
  int            run [W];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    p1 = '0; p2 = '0; exp_state = '0; exp_press = '0; exp_release = '0; exp_count = '0;
    for (int i = 0; i < W; i++) run[i] = 0;
  endtask

  task automatic tick();
    logic [W-1:0] s;
    @(posedge CLK);
    if (RST) begin
      s = p2; p2 = p1; p1 = BTN;
      exp_press = '0; exp_release = '0;
      for (int i = 0; i < W; i++) begin
        if (s[i] != exp_state[i]) begin
          run[i]++;
          if (run[i] == D + 1) begin
            exp_state[i] = s[i];
            if (s[i]) exp_press[i] = 1'b1;
            else      exp_release[i] = 1'b1;
            run[i] = 0;
          end
        end else begin
          run[i] = 0;
        end
      end
      exp_count = exp_count + CW'($countones(exp_press));
    end
    #1;
    check_eq("state", STATE, exp_state);
    check_eq("press", PRESS, exp_press);
    check_eq("release", RELEASE, exp_release);
    check_eq("count", PRESS_COUNT, exp_count);
  endtask

  task automatic do_reset(input int cycles);
    RST = 1'b0;
    #1;
    model_reset();
    repeat (cycles) tick();
    RST = 1'b1;
  endtask

  initial begin
    model_reset();
    // Reset held with all buttons pressed.
    BTN = 8'hFF;
    repeat (5) tick();
    check_eq("rst_state", STATE, 32'h0);
    check_eq("rst_count", PRESS_COUNT, 32'h0);
    RST = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      tick();
      check_eq("rst_held_press", PRESS, (k == 6) ? 32'hFF : 32'h0);
    end
    tick();
    check_eq("rst_held_press_end", PRESS, 32'h0);
    check_eq("rst_held_state", STATE, 32'hFF);
    check_eq("rst_held_count", PRESS_COUNT, 32'h8);

    // Bounce shorter than the debounce window.
    BTN = 8'h00;
    repeat (10) tick();
    do_reset(2);
    repeat (3) tick();
    for (int r = 0; r < 5; r++) begin
      BTN[0] = 1'b1; repeat (3) tick();
      BTN[0] = 1'b0; repeat (2) tick();
    end
    repeat (8) tick();
    check_eq("bounce_state", STATE, 32'h0);
    check_eq("bounce_count", PRESS_COUNT, 32'h0);

    // Clean press and release on line 2.
    BTN[2] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (k <= 6) check_eq("clean_press2", 32'(PRESS[2]), (k == 6) ? 32'h1 : 32'h0);
    end
    check_eq("clean_state_hi", 32'(STATE[2]), 32'h1);
    BTN[2] = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      tick();
      check_eq("clean_release2", 32'(RELEASE[2]), (k == 6) ? 32'h1 : 32'h0);
    end
    check_eq("clean_state_lo", 32'(STATE[2]), 32'h0);
    check_eq("clean_count", PRESS_COUNT, 32'h1);

    // Three lines pressed together.
    BTN = 8'hA2;
    for (int k = 0; k <= 6; k++) begin
      tick();
      check_eq("simul_press", PRESS, (k == 6) ? 32'hA2 : 32'h0);
    end
    check_eq("simul_count", PRESS_COUNT, 32'h4);
    BTN = 8'h00;
    repeat (10) tick();

    // Counter wrap: 17 presses into a 4-bit count.
    do_reset(2);
    for (int r = 0; r < 17; r++) begin
      BTN[0] = 1'b1; repeat (8) tick();
      BTN[0] = 1'b0; repeat (8) tick();
    end
    check_eq("wrap_count", PRESS_COUNT, 32'h1);

    // Reset landing inside a debounce window.
    do_reset(2);
    repeat (3) tick();
    BTN[3] = 1'b1;
    repeat (4) tick();
    check_eq("midrst_no_press", PRESS_COUNT, 32'h0);
    do_reset(1);
    for (int k = 0; k <= 6; k++) begin
      tick();
      check_eq("midrst_press3", 32'(PRESS[3]), (k == 6) ? 32'h1 : 32'h0);
    end
    check_eq("midrst_count", PRESS_COUNT, 32'h1);

    // Random traffic with occasional resets.
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < W; i++) begin
        if ($urandom_range(0, 6) == 0) BTN[i] = ~BTN[i];
      end
      if (!RST) RST = 1'b1;
      else if ($urandom_range(0, 299) == 0) begin
        RST = 1'b0;
        #1;
        model_reset();
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
